uart_byte_rx: RTL and testbench

//  Receive end of the uart_scope serial link; counterpart of uart_byte_tx (8N1, LSB first).

---
 rtl/uart_byte_rx_pkg.sv | 34 +++
 rtl/uart_byte_rx_if.sv | 31 +++
 rtl/uart_byte_rx_bps_gen.sv | 50 +++++
 rtl/uart_byte_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_byte_rx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg: shared constants for the uart_scope receive path.
// Holds the baud codes, baud rates, frame slot indices and FSM state type.
// Optional feature macro used by this slice: UART_RX_FRAME_ERR_EN.
package uart_byte_rx_pkg;

  localparam int DIV_W = 9;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int RATE_9600   = 9600;
  localparam int RATE_19200  = 19200;
  localparam int RATE_38400  = 38400;
  localparam int RATE_57600  = 57600;
  localparam int RATE_115200 = 115200;

  // slot indices within one 16-slot bit, and bit indices within a frame
  localparam logic [3:0] SLOT_WIN_FIRST = 4'd6;
  localparam logic [3:0] SLOT_WIN_LAST  = 4'd12;
  localparam logic [3:0] SLOT_BIT_END   = 4'd15;
  localparam logic [3:0] BIT_LAST_DATA  = 4'd8;
  localparam logic [7:0] SLOT_LAST      = 8'd159;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: pin/baud inputs and byte outputs of the receiver.
// frame_err only exists when UART_RX_FRAME_ERR_EN is defined.
interface uart_byte_rx_if;
  logic [2:0] baud_set;
  logic       rs232_rx;
  logic [7:0] data_byte;
  logic       rx_done;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  modport master (
    output baud_set,
    output rs232_rx,
    input  data_byte,
    input  rx_done
`ifdef UART_RX_FRAME_ERR_EN
    , input frame_err
`endif
  );

  modport slave (
    input  baud_set,
    input  rs232_rx,
    output data_byte,
    output rx_done
`ifdef UART_RX_FRAME_ERR_EN
    , output frame_err
`endif
  );
endinterface

// File: rtl/uart_byte_rx_bps_gen.sv
// uart_byte_rx_bps_gen: oversample tick generator (16 ticks per bit).
// Divisors are derived from CLK_FREQ at elaboration; codes 5-7 fall back to 9600.
module uart_byte_rx_bps_gen
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OS_RATE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [2:0] i_baud_set,
  output logic       o_tick
);

  localparam logic [DIV_W-1:0] DIVM1_9600   = DIV_W'(CLK_FREQ / (OS_RATE * RATE_9600) - 1);
  localparam logic [DIV_W-1:0] DIVM1_19200  = DIV_W'(CLK_FREQ / (OS_RATE * RATE_19200) - 1);
  localparam logic [DIV_W-1:0] DIVM1_38400  = DIV_W'(CLK_FREQ / (OS_RATE * RATE_38400) - 1);
  localparam logic [DIV_W-1:0] DIVM1_57600  = DIV_W'(CLK_FREQ / (OS_RATE * RATE_57600) - 1);
  localparam logic [DIV_W-1:0] DIVM1_115200 = DIV_W'(CLK_FREQ / (OS_RATE * RATE_115200) - 1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_div_m1;

  // terminal count for the selected baud
  always_comb begin
    case (i_baud_set)
      BAUD_9600:   w_div_m1 = DIVM1_9600;
      BAUD_19200:  w_div_m1 = DIVM1_19200;
      BAUD_38400:  w_div_m1 = DIVM1_38400;
      BAUD_57600:  w_div_m1 = DIVM1_57600;
      BAUD_115200: w_div_m1 = DIVM1_115200;
      default:     w_div_m1 = DIVM1_9600;
    endcase
  end

  // divisor counter: restarts on clear, wraps at terminal count while enabled
  always_ff @(posedge clk) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= (r_cnt == w_div_m1) ? '0 : r_cnt + DIV_W'(1);
  end

  assign o_tick = i_en & (r_cnt == w_div_m1);

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 receiver with 16x oversampling and 7-sample majority vote.
// Optional frame-error strobe enabled by UART_RX_FRAME_ERR_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for a synced 1->0 edge
//   ST_START | start bit; a high vote means glitch, return to idle
//   ST_DATA  | bits 1..8, vote shifted in LSB first
//   ST_STOP  | stop bit; vote at slot 12 accepts or drops the byte
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OS_RATE  = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_rx_if.slave  rx_if
);

  logic       r_sync1, r_sync2, r_dly;
  logic [2:0] r_baud;
  logic [7:0] r_slot;
  logic [2:0] r_sum;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_done;
  rx_state_t  r_state, w_state_nxt;

  logic       w_fall, w_start, w_active, w_tick;
  logic [3:0] w_bit, w_sub;
  logic       w_in_win, w_vote, w_vote_evt, w_bit_end;
  logic [2:0] w_sum_nxt;
  logic       w_shift_en, w_load;

  assign w_fall     = r_dly & ~r_sync2;
  assign w_start    = (r_state == ST_IDLE) & w_fall;
  assign w_active   = (r_state != ST_IDLE);
  assign w_bit      = r_slot[7:4];
  assign w_sub      = r_slot[3:0];
  assign w_in_win   = (w_sub >= SLOT_WIN_FIRST) && (w_sub <= SLOT_WIN_LAST);
  // at most 6 ones precede the slot-12 sample, so 3 bits cannot overflow
  assign w_sum_nxt  = r_sum + {2'b00, r_sync2};
  assign w_vote     = (w_sum_nxt >= 3'd4);
  assign w_vote_evt = w_tick & (w_sub == SLOT_WIN_LAST);
  assign w_bit_end  = w_tick & (w_sub == SLOT_BIT_END);

  uart_byte_rx_bps_gen #(
    .CLK_FREQ (CLK_FREQ),
    .OS_RATE  (OS_RATE)
  ) u_bps (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start),
    .i_en       (w_active),
    .i_baud_set (r_baud),
    .o_tick     (w_tick)
  );

  // two-stage synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_dly   <= 1'b1;
    end else begin
      r_sync1 <= rx_if.rs232_rx;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  // baud selection is frozen for the whole frame at start detect
  always_ff @(posedge clk) begin
    if (!rst)
      r_baud <= 3'd0;
    else if (w_start)
      r_baud <= rx_if.baud_set;
  end

  // slot counter and per-bit vote accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot <= 8'd0;
      r_sum  <= 3'd0;
    end else if (w_start) begin
      r_slot <= 8'd0;
      r_sum  <= 3'd0;
    end else if (w_tick) begin
      r_slot <= (r_slot == SLOT_LAST) ? 8'd0 : r_slot + 8'd1;
      if (w_sub == 4'd0)
        r_sum <= 3'd0;
      else if (w_in_win)
        r_sum <= w_sum_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall) w_state_nxt = ST_START;
      ST_START: begin
        if (w_vote_evt && w_vote)
          w_state_nxt = ST_IDLE;
        else if (w_bit_end)
          w_state_nxt = ST_DATA;
      end
      ST_DATA:  if (w_bit_end && (w_bit == BIT_LAST_DATA)) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_vote_evt) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output decode: shift, accept and reject strobes
  always_comb begin
    w_shift_en = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      ST_DATA: w_shift_en = w_vote_evt;
      ST_STOP: w_load     = w_vote_evt & w_vote;
      default: begin end
    endcase
  end

  // data bits arrive LSB first, so each vote enters at the top
  always_ff @(posedge clk) begin
    if (!rst)
      r_shift <= 8'h00;
    else if (w_shift_en)
      r_shift <= {w_vote, r_shift[7:1]};
  end

  // output register: byte only changes together with the rx_done strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= 8'h00;
      r_done <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load)
        r_data <= r_shift;
    end
  end

  assign rx_if.data_byte = r_data;
  assign rx_if.rx_done   = r_done;

`ifdef UART_RX_FRAME_ERR_EN
  logic r_err;

  // one-clock strobe when the stop bit votes low
  always_ff @(posedge clk) begin
    if (!rst)
      r_err <= 1'b0;
    else
      r_err <= (r_state == ST_STOP) & w_vote_evt & ~w_vote;
  end

  assign rx_if.frame_err = r_err;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx.
// Frames are synthesised from ideal bit timing; good frames queue their byte,
// a monitor pops and checks on every rx_done. Honours UART_RX_FRAME_ERR_EN.
module tb_uart_byte_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_byte_rx_if u_if();

  uart_byte_rx dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (u_if)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int bp_q[$];
  logic [7:0] last_good = 8'h00;
  logic prev_done = 1'b0;
  int err_seen = 0;
  int err_exp  = 0;
  logic [7:0] m_exp;
  int m_t0, m_bp, m_lat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int code);
    int rate;
    case (code)
      1:       rate = 19200;
      2:       rate = 38400;
      3:       rate = 57600;
      4:       rate = 115200;
      default: rate = 9600;
    endcase
    return 50_000_000 / (16 * rate);
  endfunction

  // monitor: pops the scoreboard on each rx_done
  always @(negedge clk) begin
    if (u_if.rx_done === 1'b1) begin
      total++;
      if (prev_done) begin
        bad++;
        $display("FAIL rx_done_width: got strobe on consecutive clocks, required single clock");
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rx_done: got data_byte=%h, required no strobe", u_if.data_byte);
      end else begin
        m_exp = exp_q.pop_front();
        m_t0  = start_q.pop_front();
        m_bp  = bp_q.pop_front();
        m_lat = cyc - m_t0;
        total++;
        if (u_if.data_byte !== m_exp) begin
          bad++;
          $display("FAIL rx_byte: got %h required %h", u_if.data_byte, m_exp);
        end
        total++;
        if (m_lat < (m_bp * 19) / 2 || m_lat > m_bp * 10 + 8) begin
          bad++;
          $display("FAIL rx_latency: got %0d clk, required %0d..%0d", m_lat, (m_bp * 19) / 2, m_bp * 10 + 8);
        end
      end
    end
    prev_done = (u_if.rx_done === 1'b1);
`ifdef UART_RX_FRAME_ERR_EN
    if (u_if.frame_err === 1'b1) err_seen++;
`endif
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      u_if.rs232_rx = 1'b1;
    end
  endtask

  // drive nbits bits of an 8N1 frame; only complete good frames are expected
  task automatic send_frame(input logic [7:0] b, input int code, input bit stop_ok,
                            input bit noise, input bit scramble, input int nbits);
    int bp, dv;
    logic [9:0] frame;
    logic v;
    dv = div_of(code);
    bp = dv * 16;
    frame = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
    u_if.baud_set = 3'(code);
    for (int k = 0; k < nbits; k++) begin
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (k == 0 && i == 0 && stop_ok && nbits == 10) begin
          exp_q.push_back(b);
          start_q.push_back(cyc);
          bp_q.push_back(bp);
          last_good = b;
        end
        if (scramble && k == 0 && i == 20) u_if.baud_set = 3'($urandom_range(0, 7));
        v = frame[k];
        if (noise && k >= 1 && k <= 8 && i >= bp / 2 && i < bp / 2 + dv / 2) v = ~v;
        u_if.rs232_rx = v;
      end
    end
    u_if.baud_set = 3'(code);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d frames pending, required 0", name, exp_q.size());
      exp_q.delete();
      start_q.delete();
      bp_q.delete();
    end
  endtask

  task automatic check_hold(input string name);
    total++;
    if (u_if.data_byte !== last_good) begin
      bad++;
      $display("FAIL %s: got data_byte=%h required %h", name, u_if.data_byte, last_good);
    end
  endtask

  initial begin
    logic [7:0] rb;
    bit ok;
    u_if.rs232_rx = 1'b1;
    u_if.baud_set = 3'd0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (u_if.rx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_rx_done: got %b required 0", u_if.rx_done);
    end
    check_hold("reset_data_byte");
`ifdef UART_RX_FRAME_ERR_EN
    total++;
    if (u_if.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_frame_err: got %b required 0", u_if.frame_err);
    end
`endif
    rst = 1'b1;
    repeat (2000) @(negedge clk);

    // single frame at a slower baud
    send_frame(8'haa, 2, 1'b1, 1'b0, 1'b0, 10);
    drain("t1", 400);
    check_hold("t1_hold");
    idle(50);

    // back-to-back frames at 115200
    send_frame(8'h55, 4, 1'b1, 1'b0, 1'b0, 10);
    send_frame(8'h00, 4, 1'b1, 1'b0, 1'b0, 10);
    drain("t2", 400);
    check_hold("t2_hold");
    idle(50);

    // 2-clk glitch while idle must not produce a byte
    u_if.baud_set = 3'd4;
    @(negedge clk); u_if.rs232_rx = 1'b0;
    @(negedge clk); u_if.rs232_rx = 1'b0;
    idle(600);
    check_hold("t3_glitch_hold");

    // short noise pulses inside every data bit
    send_frame(8'h3c, 4, 1'b1, 1'b1, 1'b0, 10);
    drain("t4", 400);
    check_hold("t4_noise");
    idle(50);

    // bad stop bit, then line held low (break) before returning high
    send_frame(8'hf0, 4, 1'b0, 1'b0, 1'b0, 10);
    err_exp++;
    for (int i = 0; i < 864; i++) begin
      @(negedge clk);
      u_if.rs232_rx = 1'b0;
    end
    idle(100);
    check_hold("t5_bad_stop_hold");

    // reset in mid-frame, then a clean frame
    send_frame(8'h7e, 4, 1'b1, 1'b0, 1'b0, 5);
    rst = 1'b0;
    u_if.rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_good = 8'h00;
    idle(200);
    check_hold("t6_reset_clear");
    send_frame(8'h81, 4, 1'b1, 1'b0, 1'b0, 10);
    drain("t6", 400);
    check_hold("t6_hold");
    idle(50);

    // random bytes, random stop validity, baud_set scrambled mid-frame
    for (int f = 0; f < 6; f++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(rb, 4, ok, 1'b0, 1'b1, 10);
      if (!ok) err_exp++;
      idle(60);
      drain("rand", 400);
      check_hold("rand_hold");
    end

`ifdef UART_RX_FRAME_ERR_EN
    total++;
    if (err_seen != err_exp) begin
      bad++;
      $display("FAIL frame_err_count: got %0d required %0d", err_seen, err_exp);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: got cycle limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
